// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the sequential ALU.
// ALU_REM_EN adds the REM opcode (1010) on the divide datapath.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_INC = 4'b0100;
    localparam logic [3:0] OP_DEC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1000;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_REM = 4'b1010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Ops that use the iterative datapath (divide-by-zero is screened by the caller).
    function automatic logic is_multi_cycle(input logic [3:0] op);
`ifdef ALU_REM_EN
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
`else
        return (op == OP_MUL) || (op == OP_DIV);
`endif
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one {hi,lo} register pair.
// mode=0: {hi,lo} = a*b.  mode=1: lo = a/b, hi = a%b.  WIDTH steps, first step on start.
module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi_q, lo_q, m_q;
    logic             mode_q, run_q;
    logic [CNT_W-1:0] cnt_q;

    logic             cur_mode;
    logic [WIDTH-1:0] cur_hi, cur_lo, cur_m;
    logic [WIDTH:0]   sum, shl;
    logic [WIDTH-1:0] diff;
    logic             fits, step;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;

    // On start the first step works straight from the operands, so the
    // result is ready after WIDTH edges counting the start edge.
    always_comb begin
        cur_mode = start ? mode : mode_q;
        cur_hi   = start ? '0 : hi_q;
        cur_lo   = start ? (mode ? a : b) : lo_q;
        cur_m    = start ? (mode ? b : a) : m_q;

        sum  = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_m} : '0);
        shl  = {cur_hi, cur_lo[WIDTH-1]};
        fits = (shl >= {1'b0, cur_m});
        diff = shl[WIDTH-1:0] - cur_m;

        if (!cur_mode) begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], cur_lo[WIDTH-1:1]};
        end else begin
            nxt_hi = fits ? diff : shl[WIDTH-1:0];
            nxt_lo = {cur_lo[WIDTH-2:0], fits};
        end
    end

    assign done = run_q & (cnt_q == CNT_W'(WIDTH));
    assign step = start | (run_q & ~done);
    assign lo   = lo_q;
    assign hi   = hi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            m_q    <= '0;
            mode_q <= 1'b0;
            run_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (step) begin
                hi_q   <= nxt_hi;
                lo_q   <= nxt_lo;
                m_q    <= cur_m;
                mode_q <= cur_mode;
                cnt_q  <= start ? CNT_W'(1) : cnt_q + CNT_W'(1);
            end
            if (start)
                run_q <= 1'b1;
            else if (done)
                run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked sequential ALU: single-cycle logic/add ops plus iterative MUL/DIV.
// Optional macro ALU_REM_EN enables REM (opcode 1010) via the divide datapath.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             illegal_op,
    output logic             busy
);

    state_t           state;
    logic             accept, go_multi;
    logic [WIDTH:0]   sum_ab;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_dbz, sc_ill;
    logic             md_done;
    logic [WIDTH-1:0] md_lo, md_hi, div_res;

    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready;
    assign go_multi = is_multi_cycle(op) & ((op == OP_MUL) | (b != '0));
    assign sum_ab   = {1'b0, a} + {1'b0, b};

    // Everything that finishes in one cycle, including divide-by-zero and illegal ops.
    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_dbz = 1'b0;
        sc_ill = 1'b0;
        case (op)
            OP_ADD: {sc_c, sc_res} = sum_ab;
            OP_SUB: begin sc_res = a - b;           sc_c = (a < b);  end
            OP_INC: begin sc_res = a + WIDTH'(1);   sc_c = &a;       end
            OP_DEC: begin sc_res = a - WIDTH'(1);   sc_c = (a == '0); end
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_XOR: sc_res = a ^ b;
            OP_NOT: sc_res = ~a;
            OP_MUL: sc_res = '0;
            OP_DIV: begin sc_res = '1; sc_dbz = 1'b1; end
`ifdef ALU_REM_EN
            OP_REM: begin sc_res = a;  sc_dbz = 1'b1; end
`endif
            default: sc_ill = 1'b1;
        endcase
    end

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (accept & go_multi),
        .mode  (op != OP_MUL),
        .a     (a),
        .b     (b),
        .done  (md_done),
        .lo    (md_lo),
        .hi    (md_hi)
    );

`ifdef ALU_REM_EN
    logic rem_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rem_q <= 1'b0;
        else if (accept)
            rem_q <= (op == OP_REM);
    end
    assign div_res = rem_q ? md_hi : md_lo;
`else
    assign div_res = md_lo;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            carry       <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (state == DONE && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                    // A new accept in DONE overrides the drop back to IDLE.
                    if (accept) begin
                        if (go_multi) begin
                            state     <= (op == OP_MUL) ? MUL_RUN : DIV_RUN;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            result      <= sc_res;
                            zero        <= (sc_res == '0);
                            carry       <= sc_c;
                            overflow    <= 1'b0;
                            div_by_zero <= sc_dbz;
                            illegal_op  <= sc_ill;
                        end
                    end
                end
                MUL_RUN: begin
                    if (md_done) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        out_valid   <= 1'b1;
                        result      <= md_lo;
                        zero        <= (md_lo == '0);
                        carry       <= 1'b0;
                        overflow    <= |md_hi;
                        div_by_zero <= 1'b0;
                        illegal_op  <= 1'b0;
                    end
                end
                DIV_RUN: begin
                    if (md_done) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        out_valid   <= 1'b1;
                        result      <= div_res;
                        zero        <= (div_res == '0);
                        carry       <= 1'b0;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                        illegal_op  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Randomized + directed bench for alu_seq_core against an arithmetic reference model.
module tb_alu_seq_core;

    localparam int    W = 19;
    localparam longint M = longint'(1) << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   op;
    logic [W-1:0] a, b, result;
    logic         zero, carry, overflow, div_by_zero, illegal_op, busy;

    int nchk = 0;
    int nerr = 0;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .carry       (carry),
        .overflow    (overflow),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [3:0] o, input longint x, input longint y,
                         output longint res, output logic c, output logic ov,
                         output logic dbz, output logic ill, output int lat);
        longint t;
        res = 0; c = 0; ov = 0; dbz = 0; ill = 0; lat = 1;
        case (int'(o))
            0: begin t = x + y; res = t % M; c = (t >= M); end
            1: begin res = (x - y + M) % M; c = (x < y); end
            2: begin t = x * y; res = t % M; ov = (t >= M); lat = W + 1; end
            3: if (y == 0) begin res = M - 1; dbz = 1; end
               else begin res = x / y; lat = W + 1; end
            4: begin res = (x + 1) % M; c = (x == M - 1); end
            5: begin res = (x + M - 1) % M; c = (x == 0); end
            6: res = x & y;
            7: res = x | y;
            8: res = x ^ y;
            9: res = (M - 1) - x;
`ifdef ALU_REM_EN
            10: if (y == 0) begin res = x; dbz = 1; end
                else begin res = x % y; lat = W + 1; end
`endif
            default: begin res = 0; ill = 1; end
        endcase
    endtask

    // Called at a negedge; returns at the negedge where the result is visible.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint er;
        logic   ec, eov, edbz, eill;
        int     elat, lat, bc;
        model(o, longint'(x), longint'(y), er, ec, eov, edbz, eill, elat);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'($urandom);
        a  = W'($urandom);
        b  = W'($urandom);
        lat = 1;
        bc  = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            if (busy) bc++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency",     longint'(lat), longint'(elat));
        chk("busy_cycles", longint'(bc), (elat > 1) ? longint'(W) : 0);
        chk("result",      longint'(result), er);
        chk("zero",        longint'(zero), longint'(er == 0));
        chk("carry",       longint'(carry), longint'(ec));
        chk("overflow",    longint'(overflow), longint'(eov));
        chk("div_by_zero", longint'(div_by_zero), longint'(edbz));
        chk("illegal_op",  longint'(illegal_op), longint'(eill));
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
            0: v = W'($urandom);
            1: v = '0;
            2: v = '1;
            default: v = W'($urandom_range(0, 15));
        endcase
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        @(negedge clk);
        #1;
        chk("rst_in_ready",  longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_result",    longint'(result), 0);
        chk("rst_flags",     longint'({zero, carry, overflow, div_by_zero, illegal_op}), 0);
        chk("rst_busy",      longint'(busy), 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(4'h0, 19'd10, 19'd5);
        run_op(4'h0, 19'h7FFFF, 19'd1);
        run_op(4'h2, 19'd4, 19'd3);
        run_op(4'h2, 19'h40000, 19'd4);
        run_op(4'h3, 19'd100, 19'd7);
        run_op(4'h3, 19'd5, 19'd0);
        run_op(4'h4, 19'h7FFFF, 19'd0);
        run_op(4'h5, 19'd0, 19'd0);
        run_op(4'h9, 19'h12345, 19'd0);
        run_op(4'hB, 19'd3, 19'd4);
        run_op(4'hA, 19'd100, 19'd7);
        run_op(4'hA, 19'd9, 19'd0);

        // Backpressure: result held, then same-cycle consume + accept.
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        op = 4'h1; a = 19'd5; b = 19'd10; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom);
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", longint'(out_valid), 1);
            chk("bp_result",    longint'(result), 64'h7FFFB);
            chk("bp_carry",     longint'(carry), 1);
            chk("bp_in_ready",  longint'(in_ready), 0);
        end
        out_ready = 1'b1; op = 4'h4; a = 19'h7FFFF; in_valid = 1'b1;
        #1;
        chk("b2b_in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_out_valid", longint'(out_valid), 1);
        chk("b2b_result",    longint'(result), 0);
        chk("b2b_carry",     longint'(carry), 1);
        chk("b2b_zero",      longint'(zero), 1);

        // Reset in the middle of a multiply.
        op = 4'h2; a = 19'd4; b = 19'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", longint'(busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", longint'(out_valid), 0);
        chk("mid_rst_busy",      longint'(busy), 0);
        chk("mid_rst_in_ready",  longint'(in_ready), 1);
        chk("mid_rst_result",    longint'(result), 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(4'h0, 19'd10, 19'd5);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 4'($urandom_range(0, 15));
            ra = pick_operand();
            rb = pick_operand();
            run_op(ro, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
Parametrised successor to the team's 19-bit combinational ALU. Adds:
- valid/ready handshakes on input and output.
- Registered result and status flags.
- Multi-cycle shift-add multiply and restoring divide.
Sits between the register-file read stage and writeback of the 19-bit processor, with the same opcode encoding.

Parameters:
WIDTH, 19, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operation request valid
in_ready  output  1  core can accept a request this cycle
op  input  4  opcode: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 INC, 0101 DEC, 0110 AND, 0111 OR, 1000 XOR, 1001 NOT
a  input  WIDTH  operand A (INC/DEC/NOT use A only)
b  input  WIDTH  operand B
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
zero  output  1  result == 0
carry  output  1  carry-out (ADD/INC); borrow (SUB/DEC); else 0
overflow  output  1  MUL product exceeds WIDTH bits; else 0
div_by_zero  output  1  DIV with b == 0
illegal_op  output  1  opcode 1010..1111
busy  output  1  multi-cycle operation in progress

Behaviour:
- Reset values: in_ready=1, out_valid=0, result=0, all flags 0, busy=0, state IDLE, counter 0.
- Reset mid-operation aborts immediately; the partial result is discarded.
- States and transitions:
  - IDLE: accept a request when in_valid & in_ready.
    - Single-cycle ops and illegal ops go to DONE on the next edge.
    - MUL goes to MUL_RUN.
    - DIV with b!=0 goes to DIV_RUN; DIV with b==0 goes to DONE.
  - MUL_RUN: one multiplier bit per cycle for WIDTH cycles, with a 2*WIDTH accumulator. Then DONE.
  - DIV_RUN: one restoring-divide step per cycle for WIDTH cycles. Then DONE.
  - DONE: out_valid=1. Returns to IDLE on out_valid & out_ready.
- Handshake:
  - in_ready = (state==IDLE) | (state==DONE & out_ready). A back-to-back accept is allowed in the same cycle the result is consumed.
  - result and flags are held stable while out_valid & !out_ready.
- Latency from accept to out_valid:
  - 1 cycle for single-cycle ops, illegal ops and divide-by-zero.
  - WIDTH+1 cycles for MUL and for DIV with b!=0.
- busy=1 in MUL_RUN/DIV_RUN only.
- Operand registers are captured at accept; changes on a/b/op after accept are ignored.
- Arithmetic: unsigned, mod 2^WIDTH.
  - ADD: carry = bit WIDTH of a+b.
  - SUB: carry = borrow (a<b).
  - INC: 2^WIDTH-1 wraps to 0 with carry=1.
  - DEC: 0 wraps to all-ones with carry=1.
  - MUL: result = low WIDTH bits; overflow = |high WIDTH bits.
  - DIV: result = quotient (truncating).
  - DIV with b==0: result = all-ones, div_by_zero=1, zero=0.
  - Illegal opcode: result=0, illegal_op=1, zero=1.
- zero is computed from the registered result.

Optional Feature:
ALU_REM_EN
- Defined: opcode 1010 = REM. Uses the DIV datapath and latency and returns the remainder.
  - REM with b==0: result = a, div_by_zero=1.
  - 1010 is not illegal.
- Undefined: 1010 is illegal, and no remainder mux is built.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams (OP_ADD..OP_NOT, OP_REM);
  - the state enum (IDLE, MUL_RUN, DIV_RUN, DONE);
  - function is_multi_cycle(op).
- Sub-module alu_seq_muldiv: shared iterative shift-add/restoring datapath.
  - Inputs: start, mode, a, b.
  - Outputs: done, lo, hi.
  - Top-level FSM drives start and counts cycles via done.

Test Plan:
- ADD a=10,b=5, out_ready=1 -> one cycle after accept: result=15, zero=0, carry=0; ADD a=0x7FFFF,b=1 -> result=0, zero=1, carry=1.
- MUL a=4,b=3 -> out_valid exactly 20 cycles after accept (WIDTH=19), busy high 19 cycles, result=12, overflow=0; MUL a=0x40000,b=4 -> result=0, overflow=1.
- DIV a=100,b=7 -> result=14 after 20 cycles; DIV a=5,b=0 -> next cycle result=0x7FFFF, div_by_zero=1.
- Backpressure: SUB a=5,b=10 with out_ready=0 for 5 cycles -> result=0x7FFFB, carry=1 held stable, in_ready=0; raise out_ready with a new in_valid INC a=0x7FFFF -> accepted same cycle, next result=0, carry=1.
- Reset asserted mid-MUL (cycle 7) -> out_valid=0, busy=0, in_ready=1 immediately; the next ADD completes normally.
- op=1011 -> illegal_op=1, result=0; with ALU_REM_EN, op=1010 a=100,b=7 -> result=2.
